// File: rtl/plic_claim_arb_pkg.sv
// Shared types and defaults for the PLIC claim/complete arbiter.
package plic_claim_arb_pkg;

   localparam int unsigned ArbReqNum   = 4;
   localparam int unsigned ArbIrqWidth = 5;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StResp  = 2'd2
   } arb_state_e;

   typedef enum logic {
      OpClaim    = 1'b0,
      OpComplete = 1'b1
   } arb_op_e;

endpackage

// File: rtl/plic_claim_arb_if.sv
// Requester-side and core-side signals of the claim arbiter; slave is the arbiter's view.
interface plic_claim_arb_if
   import plic_claim_arb_pkg::*;
#(
   parameter int unsigned ReqNum   = ArbReqNum,
   parameter int unsigned IrqWidth = ArbIrqWidth
) ();

   logic [ReqNum-1:0]          clm_req;
   logic [ReqNum-1:0]          cmp_req;
   logic [ReqNum*IrqWidth-1:0] cmp_id;
   logic [ReqNum-1:0]          gnt;
   logic [IrqWidth-1:0]        rsp_id;
   logic                       err;
   logic                       busy;
   logic                       core_clam;
   logic                       core_comp;
   logic [IrqWidth-1:0]        core_id_o;
   logic [IrqWidth-1:0]        core_id_i;

   modport slave (
      input  clm_req, cmp_req, cmp_id, core_id_i,
      output gnt, rsp_id, err, busy, core_clam, core_comp, core_id_o
   );

   modport master (
      output clm_req, cmp_req, cmp_id, core_id_i,
      input  gnt, rsp_id, err, busy, core_clam, core_comp, core_id_o
   );

endinterface

// File: rtl/plic_claim_arb_rr.sv
// Round-robin picker: first set request after ptr_i, wrapping; one-hot grant plus index.
module plic_claim_arb_rr #(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0]         req_i,
   input  logic [$clog2(N)-1:0] ptr_i,
   output logic [N-1:0]         gnt_o,
   output logic [$clog2(N)-1:0] idx_o
);

   localparam int unsigned IdxW = $clog2(N);

   logic            found;
   logic [IdxW-1:0] cand;

   always_comb begin
      found = 1'b0;
      cand  = '0;
      idx_o = '0;
      gnt_o = '0;
      for (int unsigned k = 1; k <= N; k++) begin
         cand = IdxW'((32'(ptr_i) + k) % N);
         if (!found && req_i[cand]) begin
            found = 1'b1;
            idx_o = cand;
         end
      end
      if (found) gnt_o[idx_o] = 1'b1;
   end

endmodule

// File: rtl/plic_claim_arb.sv
// Shares the plic_core claim/complete port among requesters, one operation per three cycles,
// and tracks one in-flight claimed ID per requester.
module plic_claim_arb
   import plic_claim_arb_pkg::*;
#(
   parameter int unsigned ReqNum   = ArbReqNum,
   parameter int unsigned IrqWidth = ArbIrqWidth
) (
   input logic         clk_i,
   input logic         rst_n_i,
   plic_claim_arb_if.slave bus
);

   localparam int unsigned IdxW = $clog2(ReqNum);

   arb_state_e                      state_q, state_d;
   arb_op_e                         op_q, op_d;
   logic [IdxW-1:0]                 sel_q, sel_d;
   logic [ReqNum-1:0]               sel_oh_q, sel_oh_d;
   logic [IdxW-1:0]                 clm_ptr_q, clm_ptr_d, cmp_ptr_q, cmp_ptr_d;
   logic                            err_pend_q, err_pend_d;
   logic [ReqNum-1:0]               tbl_vld_q, tbl_vld_d;
   logic [ReqNum-1:0][IrqWidth-1:0] tbl_id_q, tbl_id_d;
   logic [ReqNum-1:0]               gnt_q, gnt_d;
   logic [IrqWidth-1:0]             rsp_id_q, rsp_id_d;
   logic                            err_q, err_d;
   logic                            clam_q, clam_d, comp_q, comp_d;
   logic [IrqWidth-1:0]             core_id_q, core_id_d;

   logic [ReqNum-1:0]   cmp_oh, clm_oh;
   logic [IdxW-1:0]     cmp_idx, clm_idx;
   logic [IrqWidth-1:0] cmp_slice;

   plic_claim_arb_rr #(.N(ReqNum)) u_cmp_rr (
      .req_i (bus.cmp_req),
      .ptr_i (cmp_ptr_q),
      .gnt_o (cmp_oh),
      .idx_o (cmp_idx)
   );

   plic_claim_arb_rr #(.N(ReqNum)) u_clm_rr (
      .req_i (bus.clm_req),
      .ptr_i (clm_ptr_q),
      .gnt_o (clm_oh),
      .idx_o (clm_idx)
   );

   assign cmp_slice = bus.cmp_id[cmp_idx*IrqWidth +: IrqWidth];

   always_comb begin
      state_d    = state_q;
      op_d       = op_q;
      sel_d      = sel_q;
      sel_oh_d   = sel_oh_q;
      clm_ptr_d  = clm_ptr_q;
      cmp_ptr_d  = cmp_ptr_q;
      err_pend_d = err_pend_q;
      tbl_vld_d  = tbl_vld_q;
      tbl_id_d   = tbl_id_q;
      gnt_d      = '0;
      rsp_id_d   = '0;
      err_d      = 1'b0;
      clam_d     = 1'b0;
      comp_d     = 1'b0;
      core_id_d  = '0;
      unique case (state_q)
         StIdle: begin
            // Core pulses are decided here so they appear registered during ISSUE.
            if (|bus.cmp_req) begin
               state_d  = StIssue;
               op_d     = OpComplete;
               sel_d    = cmp_idx;
               sel_oh_d = cmp_oh;
               if (tbl_vld_q[cmp_idx] && (tbl_id_q[cmp_idx] == cmp_slice)) begin
                  comp_d     = 1'b1;
                  core_id_d  = cmp_slice;
                  err_pend_d = 1'b0;
               end else begin
                  err_pend_d = 1'b1;
               end
            end else if (|bus.clm_req) begin
               state_d    = StIssue;
               op_d       = OpClaim;
               sel_d      = clm_idx;
               sel_oh_d   = clm_oh;
               clam_d     = ~tbl_vld_q[clm_idx];
               err_pend_d = tbl_vld_q[clm_idx];
            end
         end
         StIssue: begin
            state_d = StResp;
            gnt_d   = sel_oh_q;
            err_d   = err_pend_q;
            if (op_q == OpClaim) begin
               clm_ptr_d = sel_q;
               if (!err_pend_q) begin
                  rsp_id_d = bus.core_id_i;
                  // ID 0 means nothing was pending at the core; keep the entry free.
                  if (bus.core_id_i != '0) begin
                     tbl_vld_d[sel_q] = 1'b1;
                     tbl_id_d[sel_q]  = bus.core_id_i;
                  end
               end
            end else begin
               cmp_ptr_d = sel_q;
               if (!err_pend_q) begin
                  tbl_vld_d[sel_q] = 1'b0;
                  tbl_id_d[sel_q]  = '0;
               end
            end
         end
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= StIdle;
         op_q       <= OpClaim;
         sel_q      <= '0;
         sel_oh_q   <= '0;
         clm_ptr_q  <= IdxW'(ReqNum - 1);
         cmp_ptr_q  <= IdxW'(ReqNum - 1);
         err_pend_q <= 1'b0;
         tbl_vld_q  <= '0;
         tbl_id_q   <= '0;
         gnt_q      <= '0;
         rsp_id_q   <= '0;
         err_q      <= 1'b0;
         clam_q     <= 1'b0;
         comp_q     <= 1'b0;
         core_id_q  <= '0;
      end else begin
         state_q    <= state_d;
         op_q       <= op_d;
         sel_q      <= sel_d;
         sel_oh_q   <= sel_oh_d;
         clm_ptr_q  <= clm_ptr_d;
         cmp_ptr_q  <= cmp_ptr_d;
         err_pend_q <= err_pend_d;
         tbl_vld_q  <= tbl_vld_d;
         tbl_id_q   <= tbl_id_d;
         gnt_q      <= gnt_d;
         rsp_id_q   <= rsp_id_d;
         err_q      <= err_d;
         clam_q     <= clam_d;
         comp_q     <= comp_d;
         core_id_q  <= core_id_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.err       = err_q;
   assign bus.busy      = (state_q != StIdle);
   assign bus.core_clam = clam_q;
   assign bus.core_comp = comp_q;
   assign bus.core_id_o = core_id_q;

endmodule

// File: tb/tb_plic_claim_arb.sv
// Directed and random bench for plic_claim_arb against a per-requester table model.
module tb_plic_claim_arb;

   localparam int unsigned RN = 4;
   localparam int unsigned IW = 5;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   plic_claim_arb_if #(.ReqNum(RN), .IrqWidth(IW)) bus ();

   plic_claim_arb #(.ReqNum(RN), .IrqWidth(IW)) dut (
      .clk_i   (clk),
      .rst_n_i (rst_n),
      .bus     (bus)
   );

   int total = 0;
   int bad   = 0;

   logic [RN-1:0]         m_clm, m_cmp;
   logic [RN-1:0][IW-1:0] m_cmpid;
   logic [IW-1:0]         m_core;
   bit                    mv [RN];
   int                    mid[RN];
   int                    ptr_clm, ptr_cmp;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive();
      bus.clm_req   = m_clm;
      bus.cmp_req   = m_cmp;
      bus.cmp_id    = m_cmpid;
      bus.core_id_i = m_core;
   endtask

   task automatic model_reset();
      for (int r = 0; r < RN; r++) begin
         mv[r]  = 1'b0;
         mid[r] = 0;
      end
      ptr_clm = RN - 1;
      ptr_cmp = RN - 1;
   endtask

   task automatic check_all_zero(input string tag);
      check(tag, {bus.gnt, bus.rsp_id, bus.err, bus.busy, bus.core_clam, bus.core_comp,
                  bus.core_id_o}, 0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n   = 1'b0;
      m_clm   = '0;
      m_cmp   = '0;
      m_cmpid = '0;
      m_core  = '0;
      drive();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic idle_tick();
      @(posedge clk);
      #1;
      check("idle_busy", bus.busy, 0);
      check("idle_gnt", bus.gnt, 0);
   endtask

   // One arbitration round: winner from the request levels, expected core access and response.
   task automatic serve(input bit drop_early);
      bit            is_cmp, ok;
      int            w, p;
      logic [RN-1:0] req;
      is_cmp = (m_cmp != '0);
      req    = is_cmp ? m_cmp : m_clm;
      p      = is_cmp ? ptr_cmp : ptr_clm;
      w      = 0;
      for (int k = RN; k >= 1; k--) begin
         if (req[(p + k) % RN]) w = (p + k) % RN;
      end
      ok = is_cmp ? (mv[w] && (mid[w] == int'(m_cmpid[w]))) : !mv[w];

      @(posedge clk);
      #1;
      check("issue_busy", bus.busy, 1);
      check("issue_clam", bus.core_clam, !is_cmp && ok);
      check("issue_comp", bus.core_comp, is_cmp && ok);
      check("issue_core_id", bus.core_id_o, (is_cmp && ok) ? m_cmpid[w] : 0);
      check("issue_gnt", bus.gnt, 0);
      if (drop_early) begin
         if (is_cmp) m_cmp[w] = 1'b0;
         else        m_clm[w] = 1'b0;
         drive();
      end

      @(posedge clk);
      #1;
      check("resp_gnt", bus.gnt, 1 << w);
      check("resp_err", bus.err, !ok);
      check("resp_id", bus.rsp_id, (!is_cmp && ok) ? m_core : 0);
      check("resp_pulses", {bus.core_clam, bus.core_comp}, 0);
      check("resp_busy", bus.busy, 1);
      if (is_cmp) m_cmp[w] = 1'b0;
      else        m_clm[w] = 1'b0;
      drive();

      if (is_cmp) begin
         ptr_cmp = w;
         if (ok) begin
            mv[w]  = 1'b0;
            mid[w] = 0;
         end
      end else begin
         ptr_clm = w;
         if (ok && m_core != '0) begin
            mv[w]  = 1'b1;
            mid[w] = int'(m_core);
         end
      end

      @(posedge clk);
      #1;
      check("done_busy", bus.busy, 0);
      check("done_gnt", bus.gnt, 0);
   endtask

   task automatic run_pending();
      while (m_clm != '0 || m_cmp != '0) serve(1'b0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n   = 1'b0;
      m_clm   = '0;
      m_cmp   = '0;
      m_cmpid = '0;
      m_core  = '0;
      drive();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all_zero("reset_outputs");
      @(negedge clk);
      rst_n = 1'b1;

      // Single uncontested claim.
      m_clm  = 4'b0001;
      m_core = 5'd7;
      drive();
      serve(1'b0);

      // All four claim, then a repeat claim from r0 while it still holds an ID.
      do_reset();
      m_clm  = 4'b1111;
      m_core = 5'd3;
      drive();
      run_pending();
      m_clm = 4'b0001;
      drive();
      serve(1'b0);

      // Complete match, complete on a cleared entry, and complete with a wrong ID.
      do_reset();
      m_clm  = 4'b0100;
      m_core = 5'd9;
      drive();
      serve(1'b0);
      m_cmp      = 4'b0100;
      m_cmpid[2] = 5'd9;
      drive();
      serve(1'b0);
      m_cmp = 4'b0100;
      drive();
      serve(1'b0);
      m_clm = 4'b0100;
      drive();
      serve(1'b0);
      m_cmp      = 4'b0100;
      m_cmpid[2] = 5'd8;
      drive();
      serve(1'b0);

      // Complete beats a simultaneous claim.
      m_clm  = 4'b1000;
      m_core = 5'd4;
      drive();
      serve(1'b0);
      m_clm      = 4'b0001;
      m_cmp      = 4'b1000;
      m_cmpid[3] = 5'd4;
      m_core     = 5'd5;
      drive();
      run_pending();

      // Claim returning ID 0 leaves the entry free for an immediate re-claim.
      m_core = 5'd0;
      m_clm  = 4'b0010;
      drive();
      serve(1'b0);
      m_clm = 4'b0010;
      drive();
      serve(1'b0);

      // Reset while in ISSUE.
      m_clm  = 4'b0010;
      m_core = 5'd11;
      drive();
      @(posedge clk);
      #1;
      check("midrst_clam_before", bus.core_clam, 1);
      #2;
      rst_n = 1'b0;
      #1;
      check_all_zero("midrst_async_zero");
      m_clm = '0;
      drive();
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) idle_tick();
      m_cmp      = 4'b0001;
      m_cmpid[0] = 5'd5;
      drive();
      serve(1'b0);

      // Random traffic.
      for (int it = 0; it < 300; it++) begin
         logic [RN-1:0] add_clm, add_cmp;
         add_clm = ($urandom_range(0, 2) == 0) ? RN'($urandom) : '0;
         add_cmp = ($urandom_range(0, 3) == 0) ? RN'($urandom) : '0;
         for (int r = 0; r < RN; r++) begin
            if (add_cmp[r] && !m_cmp[r]) begin
               m_cmpid[r] = (mv[r] && $urandom_range(0, 2) != 0) ? IW'(mid[r])
                                                                 : IW'($urandom_range(0, 31));
            end
         end
         m_clm  = m_clm | add_clm;
         m_cmp  = m_cmp | add_cmp;
         m_core = ($urandom_range(0, 4) == 0) ? '0 : IW'($urandom_range(1, 31));
         drive();
         if (m_clm != '0 || m_cmp != '0) serve($urandom_range(0, 3) == 0);
         else                            idle_tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
